// File: rtl/io_bus_master.sv
// io_bus_master: single-outstanding IO bus initiator with range/alignment rejection.
// Define IO_LED_SHADOW_EN to serve LED_ADDR loads from a 16-bit shadow of the last store.
module io_bus_master #(
   parameter logic [31:0] IO_BASE       = 32'h0000_0000,
   parameter int          IO_WORDS      = 1024,
   parameter int          ACCESS_CYCLES = 1,
   parameter logic [31:0] LED_ADDR      = 32'h0000_0004
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        req_ready,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        stall,
   output logic        io_ce,
   output logic        io_we,
   output logic [31:0] io_addr,
   output logic [31:0] io_wtData,
   input  logic [31:0] io_rdData
);
`ifdef IO_LED_SHADOW_EN
   localparam logic SHADOW_EN = 1'b1;
`else
   localparam logic SHADOW_EN = 1'b0;
`endif
   localparam logic [3:0]  LAST = 4'(ACCESS_CYCLES - 1);
   localparam logic [32:0] SPAN = 33'(IO_WORDS) << 2;
   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
   state_t state, nstate;
   logic [3:0] cnt;
   logic we_q, bad, accept, done, led_hit;
   logic [15:0] shadow;
   logic [31:0] load_data;
   logic [32:0] off;
   // an address below IO_BASE wraps into bit 32 and so also lands beyond SPAN
   assign off       = {1'b0, req_addr} - {1'b0, IO_BASE};
   assign bad       = (req_addr[1:0] != 2'b00) | (off >= SPAN);
   assign accept    = (state == IDLE) & req_valid;
   assign done      = (state == ACCESS) & (cnt == LAST);
   assign led_hit   = SHADOW_EN & (io_addr == LED_ADDR);
   assign load_data = led_hit ? {16'h0, shadow} : io_rdData;
   always_ff @(posedge clk)
      state <= !rst ? IDLE : nstate;
   always_comb
      nstate = state == IDLE   ? (req_valid ? (bad ? RESP : ACCESS) : IDLE) :
               state == ACCESS ? (cnt == LAST ? RESP : ACCESS) : IDLE;
   always_comb begin
      req_ready = state == IDLE;
      stall     = (state == ACCESS) | ((state == IDLE) & req_valid);
   end
   always_ff @(posedge clk)
      if (!rst) begin
         cnt        <= '0;
         we_q       <= 1'b0;
         io_ce      <= 1'b0;
         io_we      <= 1'b0;
         io_addr    <= '0;
         io_wtData  <= '0;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
      end else begin
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         resp_rdata <= '0;
         if (accept) begin
            we_q       <= req_we;
            cnt        <= '0;
            io_ce      <= !bad;
            io_we      <= !bad & req_we & (LAST == 4'd0);
            resp_valid <= bad;
            resp_err   <= bad;
            if (!bad) begin
               io_addr   <= req_addr;
               io_wtData <= req_wdata;
            end
         end else if (state == ACCESS) begin
            cnt   <= cnt + 4'd1;
            io_ce <= !done;
            // the write strobe covers only the final access cycle
            io_we <= we_q & (cnt + 4'd1 == LAST);
            if (done) begin
               resp_valid <= 1'b1;
               resp_rdata <= we_q ? '0 : load_data;
            end
         end
      end
   always_ff @(posedge clk)
      if (!rst) shadow <= '0;
      else if (done & we_q & led_hit) shadow <= io_wtData[15:0];
endmodule

// File: tb/tb_io_bus_master.sv
// tb_io_bus_master: two instances (1 and 3 access cycles) checked against a transaction-level model.
module tb_io_bus_master;
`ifdef IO_LED_SHADOW_EN
   localparam bit SH = 1'b1;
`else
   localparam bit SH = 1'b0;
`endif
   logic clk = 1'b0, rst = 1'b0, req_valid = 1'b0, req_we = 1'b0;
   logic [31:0] req_addr = '0, req_wdata = '0, io_rdData = '0;
   logic rdy[2], rv[2], re[2], st[2], ce[2], we[2];
   logic [31:0] rd[2], ia[2], iw[2];
   int n_cmp = 0, n_bad = 0, cyc = 0;
   bit chk_en = 1'b0;
   bit act[2], merr[2], mwe[2];
   int acc[2];
   logic [31:0] maddr[2], mwd[2], mrd[2];
   logic [15:0] msh[2];
   bit e_ce, e_we, e_rv, e_rdy, e_st;

   io_bus_master #(.ACCESS_CYCLES(1)) u1 (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_ready(rdy[0]), .resp_valid(rv[0]), .resp_rdata(rd[0]),
      .resp_err(re[0]), .stall(st[0]), .io_ce(ce[0]), .io_we(we[0]), .io_addr(ia[0]),
      .io_wtData(iw[0]), .io_rdData(io_rdData));
   io_bus_master #(.ACCESS_CYCLES(3)) u3 (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_ready(rdy[1]), .resp_valid(rv[1]), .resp_rdata(rd[1]),
      .resp_err(re[1]), .stall(st[1]), .io_ce(ce[1]), .io_we(we[1]), .io_addr(ia[1]),
      .io_wtData(iw[1]), .io_rdData(io_rdData));

   always #5 clk = ~clk;

   function automatic int ncyc(int i);
      return i == 0 ? 1 : 3;
   endfunction
   function automatic int resp_at(int i);
      return acc[i] + (merr[i] ? 1 : ncyc(i) + 1);
   endfunction
   function automatic bit idle_at(int i, int c);
      return !act[i] || c > resp_at(i);
   endfunction

   task automatic chk(input string nm, input int d, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s dut%0d cyc %0d: got %h want %h", nm, d, cyc, got, want);
      end
   endtask

   // transaction model: acceptance at cycle acc gives io_ce in acc+1..acc+N and the response in acc+N+1
   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (!rst) begin
            act[i] = 1'b0;
            msh[i] = '0;
         end else begin
            if (act[i] && !merr[i] && cyc == acc[i] + ncyc(i)) begin
               if (mwe[i]) begin
                  if (SH && maddr[i] == 32'h4) msh[i] = mwd[i][15:0];
               end else
                  mrd[i] = (SH && maddr[i] == 32'h4) ? {16'h0, msh[i]} : io_rdData;
            end
            if (idle_at(i, cyc) && req_valid) begin
               act[i]   = 1'b1;
               acc[i]   = cyc;
               mwe[i]   = req_we;
               maddr[i] = req_addr;
               mwd[i]   = req_wdata;
               merr[i]  = (req_addr % 4 != 0) || (longint'(req_addr) >= 64'd4 * 1024);
            end
         end
      end
      cyc++;
      chk_en = 1'b1;
   end

   always @(negedge clk) begin
      if (chk_en) begin
         for (int i = 0; i < 2; i++) begin
            e_ce  = act[i] && !merr[i] && cyc > acc[i] && cyc <= acc[i] + ncyc(i);
            e_we  = e_ce && mwe[i] && cyc == acc[i] + ncyc(i);
            e_rv  = act[i] && cyc == resp_at(i);
            e_rdy = idle_at(i, cyc);
            e_st  = e_ce || (e_rdy && req_valid);
            chk("io_ce", i, 32'(ce[i]), 32'(e_ce));
            chk("io_we", i, 32'(we[i]), 32'(e_we));
            chk("resp_valid", i, 32'(rv[i]), 32'(e_rv));
            chk("req_ready", i, 32'(rdy[i]), 32'(e_rdy));
            chk("stall", i, 32'(st[i]), 32'(e_st));
            if (e_ce) begin
               chk("io_addr", i, ia[i], maddr[i]);
               chk("io_wtData", i, iw[i], mwd[i]);
            end
            if (e_rv) begin
               chk("resp_err", i, 32'(re[i]), 32'(merr[i]));
               chk("resp_rdata", i, rd[i], (merr[i] || mwe[i]) ? 32'h0 : mrd[i]);
            end
         end
      end
   end

   task automatic present(input logic w, input logic [31:0] a, input logic [31:0] d);
      req_valid = 1'b1;
      req_we    = w;
      req_addr  = a;
      req_wdata = d;
      @(posedge clk);
      #1 req_valid = 1'b0;
   endtask

   task automatic pick_addr(output logic [31:0] a);
      case ($urandom_range(0, 7))
         0: a = 32'($urandom_range(0, 1023)) << 2;
         1: a = 32'h4;
         2: a = 32'hFFC;
         3: a = 32'h1000;
         4: a = $urandom;
         5: a = 32'($urandom_range(0, 4095));
         6: a = 32'hFFFF_FFFC;
         default: a = 32'h0;
      endcase
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         chk("rst_io_ce", i, 32'(ce[i]), 32'h0);
         chk("rst_io_we", i, 32'(we[i]), 32'h0);
         chk("rst_resp_valid", i, 32'(rv[i]), 32'h0);
         chk("rst_resp_err", i, 32'(re[i]), 32'h0);
         chk("rst_resp_rdata", i, rd[i], 32'h0);
         chk("rst_io_addr", i, ia[i], 32'h0);
         chk("rst_io_wtData", i, iw[i], 32'h0);
      end
      rst = 1'b1;
      // load 0x0 returning 1
      io_rdData = 32'h1;
      present(1'b0, 32'h0, 32'hDEAD_BEEF);
      @(negedge clk);
      chk("ld_ce_t1", 0, 32'(ce[0]), 32'h1);
      chk("ld_ce_t1", 1, 32'(ce[1]), 32'h1);
      @(negedge clk);
      chk("ld_ce_t2", 0, 32'(ce[0]), 32'h0);
      chk("ld_rv_t2", 0, 32'(rv[0]), 32'h1);
      chk("ld_rdata", 0, rd[0], 32'h1);
      chk("ld_err", 0, 32'(re[0]), 32'h0);
      chk("ld_stall_resp", 0, 32'(st[0]), 32'h0);
      @(negedge clk);
      chk("ld_ce_t3", 1, 32'(ce[1]), 32'h1);
      @(negedge clk);
      chk("ld_rv_t4", 1, 32'(rv[1]), 32'h1);
      chk("ld_rdata", 1, rd[1], 32'h1);
      @(posedge clk);
      #1;
      // store 0x4 = 0xA5A5
      present(1'b1, 32'h4, 32'hA5A5);
      @(negedge clk);
      chk("st_we_t1", 0, 32'(we[0]), 32'h1);
      chk("st_we_t1", 1, 32'(we[1]), 32'h0);
      chk("st_addr", 1, ia[1], 32'h4);
      chk("st_wdata", 1, iw[1], 32'hA5A5);
      @(negedge clk);
      chk("st_we_t2", 1, 32'(we[1]), 32'h0);
      @(negedge clk);
      chk("st_ce_t3", 1, 32'(ce[1]), 32'h1);
      chk("st_we_t3", 1, 32'(we[1]), 32'h1);
      @(negedge clk);
      chk("st_ce_t4", 1, 32'(ce[1]), 32'h0);
      chk("st_rv_t4", 1, 32'(rv[1]), 32'h1);
      chk("st_rdata", 1, rd[1], 32'h0);
      @(posedge clk);
      #1;
      // misaligned and out-of-range rejections
      present(1'b0, 32'h1002, 32'h0);
      @(negedge clk);
      chk("mis_ce", 1, 32'(ce[1]), 32'h0);
      chk("mis_err", 1, 32'(re[1]), 32'h1);
      chk("mis_rv", 0, 32'(rv[0]), 32'h1);
      @(posedge clk);
      #1;
      present(1'b1, 32'h1000, 32'h0);
      @(negedge clk);
      chk("oor_ce", 0, 32'(ce[0]), 32'h0);
      chk("oor_err", 0, 32'(re[0]), 32'h1);
      chk("oor_rv", 1, 32'(rv[1]), 32'h1);
      @(posedge clk);
      #1;
`ifdef IO_LED_SHADOW_EN
      present(1'b1, 32'h4, 32'h00FF);
      repeat (4) @(posedge clk);
      #1 io_rdData = 32'h0;
      present(1'b0, 32'h4, 32'h0);
      @(negedge clk);
      @(negedge clk);
      chk("led_rdata", 0, rd[0], 32'h00FF);
      @(negedge clk);
      @(negedge clk);
      chk("led_rdata", 1, rd[1], 32'h00FF);
      @(posedge clk);
      #1;
`endif
      // reset held two cycles in the middle of a store
      present(1'b1, 32'h8, 32'h1234);
      @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_mid_ce", 1, 32'(ce[1]), 32'h0);
      chk("rst_mid_we", 1, 32'(we[1]), 32'h0);
      @(posedge clk);
      #1 rst = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("rst_mid_rv", 1, 32'(rv[1]), 32'h0);
      end
      @(posedge clk);
      #1;
      // valid held high back-to-back
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = 32'h10;
      for (int k = 0; k < 16; k++) begin
         io_rdData = $urandom;
         @(posedge clk);
         #1;
      end
      // randomized traffic
      for (int k = 0; k < 3000; k++) begin
         rst       = ($urandom_range(0, 149) != 0);
         req_valid = ($urandom_range(0, 3) != 0);
         req_we    = 1'($urandom);
         pick_addr(req_addr);
         req_wdata = $urandom;
         io_rdData = $urandom;
         @(posedge clk);
         #1;
      end
      rst       = 1'b1;
      req_valid = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
